// File: rtl/host_cmd_master.sv
// Host-side UART command initiator: serializes one command frame and gathers its 0-2 byte reply.
// Optional response timeout is enabled by defining HOST_TIMEOUT_EN.
module host_cmd_master #(
  parameter int         TIMEOUT_CYC = 65535,
  parameter logic [3:0] MUL_FUN     = 4'b0010
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VLD,
  output logic        REQ_RDY,
  input  logic [1:0]  REQ_TYPE,
  input  logic [3:0]  REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  input  logic [7:0]  REQ_OPA,
  input  logic [7:0]  REQ_OPB,
  input  logic [3:0]  REQ_FUN,
  output logic [7:0]  TX_P_DATA,
  output logic        TX_D_VLD,
  input  logic        TX_BUSY,
  input  logic [7:0]  RX_P_DATA,
  input  logic        RX_D_VLD,
  output logic [15:0] RSP_DATA,
  output logic        RSP_VLD,
  output logic        RSP_ERR
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    GAP      = 3'd2,
    WAIT_RSP = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  function automatic logic [7:0] frame_byte(
    input logic [1:0] typ,
    input logic [1:0] idx,
    input logic [3:0] addr,
    input logic [7:0] wdata,
    input logic [7:0] opa,
    input logic [7:0] opb,
    input logic [3:0] fun
  );
    logic [7:0] b;
    case (typ)
      2'b00: begin
        case (idx)
          2'd0:    b = 8'hAA;
          2'd1:    b = {4'h0, addr};
          default: b = wdata;
        endcase
      end
      2'b01:   b = (idx == 2'd0) ? 8'hBB : {4'h0, addr};
      2'b10: begin
        case (idx)
          2'd0:    b = 8'hCC;
          2'd1:    b = opa;
          2'd2:    b = opb;
          default: b = {4'h0, fun};
        endcase
      end
      default: b = (idx == 2'd0) ? 8'hDD : {4'h0, fun};
    endcase
    return b;
  endfunction

  // Index of the final byte in the frame
  function automatic logic [1:0] frame_last(input logic [1:0] typ);
    logic [1:0] n;
    case (typ)
      2'b00:   n = 2'd2;
      2'b01:   n = 2'd1;
      2'b10:   n = 2'd3;
      default: n = 2'd1;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] rsp_count(input logic [1:0] typ, input logic [3:0] fun);
    logic [1:0] n;
    case (typ)
      2'b00:   n = 2'd0;
      2'b01:   n = 2'd1;
      default: n = (fun == MUL_FUN) ? 2'd2 : 2'd1;
    endcase
    return n;
  endfunction

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [1:0]  r_rx_cnt;
  logic [1:0]  r_type;
  logic [3:0]  r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_opa;
  logic [7:0]  r_opb;
  logic [3:0]  r_fun;
  logic [7:0]  r_rsp0;
  logic [7:0]  r_rsp1;
  logic [7:0]  r_tx_data;
  logic        r_tx_vld;
  logic        r_req_rdy;
  logic        r_rsp_vld;
  logic        r_rsp_err;

  state_t      w_next_state;
  logic [1:0]  w_idx_next;
  logic [1:0]  w_rx_cnt_next;
  logic [1:0]  w_rx_cnt_inc;
  logic [1:0]  w_last;
  logic [1:0]  w_exp;
  logic        w_accept;
  logic        w_rx_store;
  logic        w_timeout;
  logic [1:0]  w_src_type;
  logic [3:0]  w_src_addr;
  logic [7:0]  w_src_wdata;
  logic [7:0]  w_src_opa;
  logic [7:0]  w_src_opb;
  logic [3:0]  w_src_fun;
  logic [7:0]  w_tx_byte;

`ifdef HOST_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        w_to_hit;
  assign w_to_hit = (r_to_cnt == TO_LIM);
`else
  logic        w_unused_to;
  assign w_unused_to = ^TO_LIM;
`endif

  assign w_last       = frame_last(r_type);
  assign w_exp        = rsp_count(r_type, r_fun);
  assign w_rx_cnt_inc = r_rx_cnt + 2'd1;

  // Next-state, byte index and response-capture control
  always_comb begin
    w_next_state  = r_state;
    w_idx_next    = r_idx;
    w_rx_cnt_next = r_rx_cnt;
    w_accept      = 1'b0;
    w_rx_store    = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      IDLE: begin
        if (REQ_VLD) begin
          w_accept      = 1'b1;
          w_next_state  = SEND;
          w_idx_next    = 2'd0;
          w_rx_cnt_next = 2'd0;
        end else begin
          w_next_state  = IDLE;
        end
      end
      SEND: begin
        if (!TX_BUSY) begin
          w_idx_next   = r_idx + 2'd1;
          w_next_state = (r_idx == w_last) ? WAIT_RSP : GAP;
        end else begin
          w_next_state = SEND;
        end
      end
      GAP: w_next_state = SEND;
      WAIT_RSP: begin
        if (w_exp == 2'd0) begin
          w_next_state = DONE;
        end else if (RX_D_VLD) begin
          w_rx_store    = 1'b1;
          w_rx_cnt_next = w_rx_cnt_inc;
          w_next_state  = (w_rx_cnt_inc == w_exp) ? DONE : WAIT_RSP;
`ifdef HOST_TIMEOUT_EN
        end else if (w_to_hit) begin
          w_timeout    = 1'b1;
          w_next_state = DONE;
`endif
        end else begin
          w_next_state = WAIT_RSP;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // On the accept cycle the request fields are not yet captured, so drive the first byte from the inputs
  always_comb begin
    if (w_accept) begin
      w_src_type  = REQ_TYPE;
      w_src_addr  = REQ_ADDR;
      w_src_wdata = REQ_WDATA;
      w_src_opa   = REQ_OPA;
      w_src_opb   = REQ_OPB;
      w_src_fun   = REQ_FUN;
    end else begin
      w_src_type  = r_type;
      w_src_addr  = r_addr;
      w_src_wdata = r_wdata;
      w_src_opa   = r_opa;
      w_src_opb   = r_opb;
      w_src_fun   = r_fun;
    end
    w_tx_byte = frame_byte(w_src_type, w_idx_next, w_src_addr, w_src_wdata,
                           w_src_opa, w_src_opb, w_src_fun);
  end

  // State, capture registers and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_idx     <= 2'd0;
      r_rx_cnt  <= 2'd0;
      r_type    <= 2'd0;
      r_addr    <= 4'd0;
      r_wdata   <= 8'd0;
      r_opa     <= 8'd0;
      r_opb     <= 8'd0;
      r_fun     <= 4'd0;
      r_rsp0    <= 8'd0;
      r_rsp1    <= 8'd0;
      r_tx_data <= 8'd0;
      r_tx_vld  <= 1'b0;
      r_req_rdy <= 1'b1;
      r_rsp_vld <= 1'b0;
      r_rsp_err <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_idx    <= w_idx_next;
      r_rx_cnt <= w_rx_cnt_next;
      if (w_accept) begin
        r_type  <= REQ_TYPE;
        r_addr  <= REQ_ADDR;
        r_wdata <= REQ_WDATA;
        r_opa   <= REQ_OPA;
        r_opb   <= REQ_OPB;
        r_fun   <= REQ_FUN;
        r_rsp0  <= 8'd0;
        r_rsp1  <= 8'd0;
      end else if (w_rx_store) begin
        if (r_rx_cnt == 2'd0) begin
          r_rsp0 <= RX_P_DATA;
        end else begin
          r_rsp1 <= RX_P_DATA;
        end
      end
      if (w_next_state == SEND) begin
        r_tx_data <= w_tx_byte;
      end
      r_tx_vld  <= (w_next_state == SEND);
      r_req_rdy <= (w_next_state == IDLE);
      r_rsp_vld <= (w_next_state == DONE);
      r_rsp_err <= w_timeout;
    end
  end

`ifdef HOST_TIMEOUT_EN
  // Inter-byte silence counter, only running while awaiting a reply
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_to_cnt <= 16'd0;
    end else if (r_state == WAIT_RSP && !RX_D_VLD) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end else begin
      r_to_cnt <= 16'd0;
    end
  end
  assign RSP_ERR = r_rsp_err;
`else
  logic w_unused_err;
  assign w_unused_err = r_rsp_err;
  assign RSP_ERR      = 1'b0;
`endif

  assign REQ_RDY   = r_req_rdy;
  assign TX_P_DATA = r_tx_data;
  assign TX_D_VLD  = r_tx_vld;
  assign RSP_DATA  = {r_rsp1, r_rsp0};
  assign RSP_VLD   = r_rsp_vld;

endmodule

// File: tb/tb_host_cmd_master.sv
// Bench for host_cmd_master: directed vector table, randomized commands against a frame/response model,
// and a mid-frame reset sequence.
module tb_host_cmd_master;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VLD;
  logic        REQ_RDY;
  logic [1:0]  REQ_TYPE;
  logic [3:0]  REQ_ADDR;
  logic [7:0]  REQ_WDATA;
  logic [7:0]  REQ_OPA;
  logic [7:0]  REQ_OPB;
  logic [3:0]  REQ_FUN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_BUSY;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [15:0] RSP_DATA;
  logic        RSP_VLD;
  logic        RSP_ERR;

  host_cmd_master #(.TIMEOUT_CYC(20), .MUL_FUN(4'b0010)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VLD(REQ_VLD), .REQ_RDY(REQ_RDY), .REQ_TYPE(REQ_TYPE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB), .REQ_FUN(REQ_FUN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RSP_DATA(RSP_DATA), .RSP_VLD(RSP_VLD), .RSP_ERR(RSP_ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_tx[$];

  typedef struct {
    logic [1:0]  typ;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  opa;
    logic [7:0]  opb;
    logic [3:0]  fun;
    int          busy;
    bit          stray;
    logic [7:0]  rx0;
    logic [7:0]  rx1;
    int          rx_gap;
    int          nbytes;
    logic [7:0]  f0, f1, f2, f3;
    int          nrx;
    logic [15:0] rsp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_rdy"}, 32'(REQ_RDY), 32'd1);
    chk({tag, "_tx_vld"},  32'(TX_D_VLD), 32'd0);
    chk({tag, "_tx_data"}, 32'(TX_P_DATA), 32'd0);
    chk({tag, "_rsp_data"}, 32'(RSP_DATA), 32'd0);
    chk({tag, "_rsp_vld"}, 32'(RSP_VLD), 32'd0);
    chk({tag, "_rsp_err"}, 32'(RSP_ERR), 32'd0);
  endtask

  // Reference model: the frame each command type produces
  task automatic model_frame(input logic [1:0] typ, input logic [3:0] addr, input logic [7:0] wdata,
                             input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] fun);
    exp_tx.delete();
    case (typ)
      2'b00: begin exp_tx.push_back(8'hAA); exp_tx.push_back({4'h0, addr}); exp_tx.push_back(wdata); end
      2'b01: begin exp_tx.push_back(8'hBB); exp_tx.push_back({4'h0, addr}); end
      2'b10: begin exp_tx.push_back(8'hCC); exp_tx.push_back(opa); exp_tx.push_back(opb);
                   exp_tx.push_back({4'h0, fun}); end
      default: begin exp_tx.push_back(8'hDD); exp_tx.push_back({4'h0, fun}); end
    endcase
  endtask

  function automatic int model_nrx(input logic [1:0] typ, input logic [3:0] fun);
    if (typ == 2'b00) return 0;
    if (typ == 2'b01) return 1;
    return (fun == 4'd2) ? 2 : 1;
  endfunction

  // Drive one command at negedges and check every cycle against exp_tx / expected response
  task automatic run_cmd(input logic [1:0] typ, input logic [3:0] addr, input logic [7:0] wdata,
                         input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] fun,
                         input int busy, input bit stray, input logic [7:0] rx0, input logic [7:0] rx1,
                         input int rx_gap, input int nrx, input int wait_cyc,
                         input logic [15:0] exp_rsp, input bit exp_err);
    int n;
    n = exp_tx.size();
    @(negedge CLK);
    chk("req_rdy_idle", 32'(REQ_RDY), 32'd1);
    REQ_VLD = 1'b1; REQ_TYPE = typ; REQ_ADDR = addr; REQ_WDATA = wdata;
    REQ_OPA = opa; REQ_OPB = opb; REQ_FUN = fun;
    RX_D_VLD = stray; RX_P_DATA = 8'hEE;
    @(negedge CLK);
    REQ_VLD = 1'b0; RX_D_VLD = 1'b0;
    REQ_TYPE = 2'($urandom); REQ_ADDR = 4'($urandom); REQ_WDATA = 8'($urandom);
    REQ_OPA = 8'($urandom); REQ_OPB = 8'($urandom); REQ_FUN = 4'($urandom);
    chk("req_rdy_busy", 32'(REQ_RDY), 32'd0);
    for (int k = 0; k < n; k++) begin
      chk("tx_vld", 32'(TX_D_VLD), 32'd1);
      chk("tx_byte", 32'(TX_P_DATA), 32'(exp_tx[k]));
      for (int b = 0; b < busy; b++) begin
        TX_BUSY = 1'b1; RX_D_VLD = stray; RX_P_DATA = 8'($urandom);
        @(negedge CLK);
        RX_D_VLD = 1'b0;
        chk("tx_hold_vld", 32'(TX_D_VLD), 32'd1);
        chk("tx_hold_byte", 32'(TX_P_DATA), 32'(exp_tx[k]));
      end
      TX_BUSY = 1'b0;
      @(negedge CLK);
      if (k != n - 1) begin
        chk("tx_gap", 32'(TX_D_VLD), 32'd0);
        TX_BUSY = 1'b1;
        @(negedge CLK);
      end
    end
    TX_BUSY = 1'b0;
    chk("tx_quiet", 32'(TX_D_VLD), 32'd0);
    if (nrx == 0) begin
      for (int w = 0; w < wait_cyc; w++) begin
        chk("rsp_early", 32'(RSP_VLD), 32'd0);
        @(negedge CLK);
      end
    end else begin
      for (int r = 0; r < nrx; r++) begin
        for (int g = 0; g < rx_gap; g++) begin
          chk("rsp_early", 32'(RSP_VLD), 32'd0);
          @(negedge CLK);
        end
        chk("rsp_early", 32'(RSP_VLD), 32'd0);
        RX_D_VLD = 1'b1; RX_P_DATA = (r == 0) ? rx0 : rx1;
        @(negedge CLK);
        RX_D_VLD = 1'b0;
      end
    end
    chk("rsp_vld", 32'(RSP_VLD), 32'd1);
    chk("rsp_data", 32'(RSP_DATA), 32'(exp_rsp));
    chk("rsp_err", 32'(RSP_ERR), 32'(exp_err));
    chk("req_rdy_done", 32'(REQ_RDY), 32'd0);
    RX_D_VLD = 1'b1; RX_P_DATA = 8'hA5;
    @(negedge CLK);
    RX_D_VLD = 1'b0;
    chk("rsp_pulse", 32'(RSP_VLD), 32'd0);
    chk("rsp_held", 32'(RSP_DATA), 32'(exp_rsp));
    chk("req_rdy_back", 32'(REQ_RDY), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    logic [1:0]  t;
    logic [3:0]  a, f;
    logic [7:0]  wd, oa, ob, x0, x1;
    logic [15:0] rsp;
    int          nr;

    vecs[0] = '{2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 0, 1'b0, 8'h00, 8'h00, 0,
                3, 8'hAA, 8'h05, 8'h3C, 8'h00, 0, 16'h0000};
    vecs[1] = '{2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 0, 1'b0, 8'h7E, 8'h00, 0,
                2, 8'hBB, 8'h02, 8'h00, 8'h00, 1, 16'h007E};
    vecs[2] = '{2'b10, 4'h0, 8'h00, 8'h0A, 8'h03, 4'h2, 0, 1'b0, 8'h1E, 8'h00, 2,
                4, 8'hCC, 8'h0A, 8'h03, 8'h02, 2, 16'h001E};
    vecs[3] = '{2'b10, 4'h0, 8'h00, 8'h0A, 8'h03, 4'h0, 0, 1'b0, 8'h0D, 8'h00, 0,
                4, 8'hCC, 8'h0A, 8'h03, 8'h00, 1, 16'h000D};
    vecs[4] = '{2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h1, 10, 1'b1, 8'h5A, 8'h00, 1,
                2, 8'hDD, 8'h01, 8'h00, 8'h00, 1, 16'h005A};
    vecs[5] = '{2'b10, 4'hF, 8'hFF, 8'h81, 8'h7F, 4'h2, 2, 1'b1, 8'h34, 8'h12, 3,
                4, 8'hCC, 8'h81, 8'h7F, 8'h02, 2, 16'h1234};

    RST = 1'b0; REQ_VLD = 1'b0; REQ_TYPE = 2'd0; REQ_ADDR = 4'd0; REQ_WDATA = 8'd0;
    REQ_OPA = 8'd0; REQ_OPB = 8'd0; REQ_FUN = 4'd0; TX_BUSY = 1'b0;
    RX_P_DATA = 8'd0; RX_D_VLD = 1'b0;
    repeat (2) @(negedge CLK);
    chk_reset_vals("reset");
    RST = 1'b1;
    @(negedge CLK);
    chk_reset_vals("post_reset");

    foreach (vecs[i]) begin
      exp_tx.delete();
      exp_tx.push_back(vecs[i].f0);
      if (vecs[i].nbytes > 1) exp_tx.push_back(vecs[i].f1);
      if (vecs[i].nbytes > 2) exp_tx.push_back(vecs[i].f2);
      if (vecs[i].nbytes > 3) exp_tx.push_back(vecs[i].f3);
      run_cmd(vecs[i].typ, vecs[i].addr, vecs[i].wdata, vecs[i].opa, vecs[i].opb, vecs[i].fun,
              vecs[i].busy, vecs[i].stray, vecs[i].rx0, vecs[i].rx1, vecs[i].rx_gap,
              vecs[i].nrx, 1, vecs[i].rsp, 1'b0);
    end

    for (int it = 0; it < 40; it++) begin
      t  = 2'($urandom_range(0, 3));
      a  = 4'($urandom); wd = 8'($urandom); oa = 8'($urandom); ob = 8'($urandom);
      f  = 4'($urandom_range(0, 3));
      x0 = 8'($urandom); x1 = 8'($urandom);
      model_frame(t, a, wd, oa, ob, f);
      nr = model_nrx(t, f);
      rsp = (nr == 0) ? 16'h0000 : (nr == 1) ? {8'h00, x0} : {x1, x0};
      run_cmd(t, a, wd, oa, ob, f, $urandom_range(0, 3), 1'($urandom), x0, x1,
              $urandom_range(0, 3), nr, 1, rsp, 1'b0);
    end

`ifdef HOST_TIMEOUT_EN
    model_frame(2'b01, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0);
    run_cmd(2'b01, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0, 0, 1'b0, 8'h00, 8'h00, 0, 0, 21,
            16'h0000, 1'b1);
`endif

    // Abort a write in the gap after its second byte
    @(negedge CLK);
    REQ_VLD = 1'b1; REQ_TYPE = 2'b00; REQ_ADDR = 4'h9; REQ_WDATA = 8'h77; TX_BUSY = 1'b0;
    @(negedge CLK);
    REQ_VLD = 1'b0;
    chk("abort_b0", 32'(TX_P_DATA), 32'h0AA);
    @(negedge CLK);
    chk("abort_gap0", 32'(TX_D_VLD), 32'd0);
    @(negedge CLK);
    chk("abort_b1", 32'(TX_P_DATA), 32'h009);
    @(negedge CLK);
    chk("abort_gap1", 32'(TX_D_VLD), 32'd0);
    RST = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk_reset_vals("abort_idle");
    repeat (3) @(negedge CLK);
    chk("abort_no_resume", 32'(TX_D_VLD), 32'd0);
    model_frame(2'b01, 4'hC, 8'h00, 8'h00, 8'h00, 4'h0);
    run_cmd(2'b01, 4'hC, 8'h00, 8'h00, 8'h00, 4'h0, 1, 1'b0, 8'hC3, 8'h00, 1, 1, 1,
            16'h00C3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
